zoled_digit_refresher: RTL and testbench
========================================

Name: zoled_digit_refresher

Overview:
- Parametrised successor to the fixed-step OLED sequencer in the photon counter.
- Drives the existing ZOLED_Module command port to do four things:
  - power-up init and GRAM clear;
  - a configurable title row;
  - continuous refresh of NUM_DIGITS BCD digits from a coherent snapshot;
  - leading-zero blanking, with a rewrite only of glyphs that changed.
- Sits between the counter/BCD converter and ZOLED_Module in the top level.

Parameters:
- NUM_DIGITS, 8, number of displayed digits (1..8).
- TITLE_LEN, 6, title glyph count (0..8; 0 = no title).
- GLYPH_W, 5, char_addr width.
- TITLE_BASE, 0, glyph address of the first title glyph; title glyph t = TITLE_BASE+t.
- DIGIT_BASE, 6, glyph address of '0'; digit v maps to DIGIT_BASE+v.
- BLANK_GLYPH, 16, glyph address written for blanked or invalid digits.
- TITLE_X0, 16, x of title glyph 0; each following glyph is +16.
- TITLE_ROW, 0, y page of the title.
- DIGIT_X0, 0, x of the most-significant digit; each following digit is +16.
- DIGIT_ROW, 2, y page of the digits.
- LZ_BLANK, 1, 1 = blank leading zeros. The least-significant digit is never blanked.
- CMD_INIT, 4'd0, CMD_CLS, 4'd1, CMD_WR, 4'd2: command codes. The top level overrides these from ZOLED_CmdList.
- Legality: DIGIT_X0+16*(NUM_DIGITS-1) <= 112 and TITLE_X0+16*(TITLE_LEN-1) <= 112.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  run enable. While low, the block finishes any in-flight command, then holds in IDLE.
- digits  in  4*NUM_DIGITS  BCD digits; nibble k is digit k, where k=0 is the least significant.
- force_full  in  1  single-cycle pulse: the next pass rewrites every digit.
- reinit  in  1  single-cycle pulse: restart from INIT after the current command completes.
- oled_en  out  1  command request to ZOLED_Module.
- cmd  out  4  command code.
- char_addr  out  GLYPH_W  glyph address.
- x  out  8  column, 0..127.
- y  out  3  page.
- oled_done  in  1  command-complete from ZOLED_Module.
- busy  out  1  high whenever not in IDLE.
- frame_done  out  1  one-cycle pulse at the end of each digit pass.

Behaviour:
- Reset: oled_en, cmd, char_addr, x, y, busy and frame_done all go to 0; the state goes to INIT; all shadow entries are invalid.
- Command handshake:
  - In an issuing state, drive cmd, x, y and char_addr and raise oled_en.
  - Hold all of them stable until oled_done is sampled high.
  - In that cycle oled_en drops to 0 and the state advances.
  - oled_en stays low for at least one cycle between consecutive commands.
  - oled_done seen while oled_en is low is ignored.
- INIT: issue CMD_INIT, x=0, y=0, char_addr=0 → CLS.
- CLS: issue CMD_CLS. On completion, invalidate every shadow entry → TITLE, or SNAP when TITLE_LEN=0.
- TITLE: for t=0..TITLE_LEN-1, issue CMD_WR with char_addr=TITLE_BASE+t, x=TITLE_X0+16t, y=TITLE_ROW → SNAP.
- SNAP (1 cycle):
  - Latch digits into snap.
  - Compute glyph g[k] for every k:
    - BLANK_GLYPH if the nibble is greater than 9;
    - BLANK_GLYPH if LZ_BLANK=1, k>0, and all nibbles k..NUM_DIGITS-1 are 0;
    - otherwise DIGIT_BASE+nibble.
  - Clear the pending force flag into a local full flag.
  - Set k=NUM_DIGITS-1 → DIGIT.
- DIGIT (processed most-significant first):
  - Write condition: full=1, or shadow[k] is invalid, or shadow[k] != g[k].
  - If the condition holds: issue CMD_WR with char_addr=g[k], x=DIGIT_X0+16*(NUM_DIGITS-1-k), y=DIGIT_ROW. On oled_done, set shadow[k]=g[k] and mark it valid.
  - If the condition does not hold: take one cycle with no command.
  - When k=0 completes, pulse frame_done → IDLE. Otherwise decrement k.
- IDLE: if en=1, go to SNAP on the next cycle. If en=0, stay.
- Pending flags:
  - force_full and reinit are captured into sticky flags in any state.
  - reinit is acted on at the next command boundary, or immediately if in IDLE. It goes → INIT and clears both flags.
  - force_full is consumed at SNAP.
- Digits changing mid-pass have no effect until the next SNAP; each pass is coherent.
- en deasserted mid-pass: the pass completes, then the block waits in IDLE.
- Reset asserted mid-command: oled_en drops in the same clock edge; ZOLED_Module shares this reset.
- busy = (state != IDLE).

Test Plan:
- Reset, then auto-complete oled_done after 3 cycles. The command sequence must be INIT, CLS, then 6 WR with (char_addr,x,y) = (0,16,0)..(5,96,0), then 8 digit WRs at x=0..112 step 16, y=2, then one frame_done pulse.
- digits=32'h00000457, LZ_BLANK=1, first pass: x=0..64 get char_addr 16; x=80,96,112 get 10,11,13. A second pass with the same digits issues no WR and still pulses frame_done.
- Change digits to 32'h00000458: the next pass issues exactly one WR (x=112, char_addr=14).
- Pulse force_full during a pass: the following pass issues all 8 WRs. Also check that 32'h0000000A gives BLANK_GLYPH at x=112.
- Stall oled_done for 50 cycles: oled_en, cmd, x, y and char_addr stay constant and oled_en is never low mid-command. Pulse reinit mid-pass: after the current WR completes the next command is INIT, and the shadow is invalidated so the following pass issues a full rewrite.

Source files
------------

// File: rtl/zoled_digit_refresher.sv
// OLED digit refresher: init, clear, title row, then coherent BCD digit passes.
// Only glyphs that differ from the on-screen shadow are rewritten.
module zoled_digit_refresher #(
    parameter int         NUM_DIGITS  = 8,
    parameter int         TITLE_LEN   = 6,
    parameter int         GLYPH_W     = 5,
    parameter int         TITLE_BASE  = 0,
    parameter int         DIGIT_BASE  = 6,
    parameter int         BLANK_GLYPH = 16,
    parameter int         TITLE_X0    = 16,
    parameter int         TITLE_ROW   = 0,
    parameter int         DIGIT_X0    = 0,
    parameter int         DIGIT_ROW   = 2,
    parameter bit         LZ_BLANK    = 1'b1,
    parameter logic [3:0] CMD_INIT    = 4'd0,
    parameter logic [3:0] CMD_CLS     = 4'd1,
    parameter logic [3:0] CMD_WR      = 4'd2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic                    force_full,
    input  logic                    reinit,
    output logic                    oled_en,
    output logic [3:0]              cmd,
    output logic [GLYPH_W-1:0]      char_addr,
    output logic [7:0]              x,
    output logic [2:0]              y,
    input  logic                    oled_done,
    output logic                    busy,
    output logic                    frame_done
);

    typedef enum logic [2:0] {
        S_INIT, S_CLS, S_TITLE, S_SNAP, S_DIGIT, S_IDLE
    } state_t;

    state_t               state, state_n;
    logic [2:0]           idx, idx_n;
    logic                 full, full_n;
    logic                 force_pend, force_pend_n;
    logic                 reinit_pend, reinit_pend_n;
    logic [GLYPH_W-1:0]   g [NUM_DIGITS];
    logic [GLYPH_W-1:0]   g_n [NUM_DIGITS];
    logic [GLYPH_W-1:0]   g_calc [NUM_DIGITS];
    logic [GLYPH_W-1:0]   sh [NUM_DIGITS];
    logic [GLYPH_W-1:0]   sh_n [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] sh_v, sh_v_n;
    logic [NUM_DIGITS:0]  allz;
    logic                 oled_en_n, busy_n, frame_done_n;
    logic [3:0]           cmd_n;
    logic [GLYPH_W-1:0]   char_addr_n;
    logic [7:0]           x_n;
    logic [2:0]           y_n;
    logic                 wr, adv;

    // allz[k]: nibbles k..NUM_DIGITS-1 are all zero
    always_comb begin
        allz = '0;
        allz[NUM_DIGITS] = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--)
            allz[k] = allz[k+1] && (digits[4*k +: 4] == 4'd0);
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (digits[4*k +: 4] > 4'd9)
                g_calc[k] = GLYPH_W'(BLANK_GLYPH);
            else if (LZ_BLANK && k > 0 && allz[k])
                g_calc[k] = GLYPH_W'(BLANK_GLYPH);
            else
                g_calc[k] = GLYPH_W'(DIGIT_BASE) + GLYPH_W'(digits[4*k +: 4]);
        end
    end

    assign wr = full || !sh_v[idx] || (sh[idx] != g[idx]);

    always_comb begin
        state_n       = state;
        idx_n         = idx;
        full_n        = full;
        force_pend_n  = force_pend | force_full;
        reinit_pend_n = reinit_pend | reinit;
        g_n           = g;
        sh_n          = sh;
        sh_v_n        = sh_v;
        oled_en_n     = oled_en;
        cmd_n         = cmd;
        char_addr_n   = char_addr;
        x_n           = x;
        y_n           = y;
        frame_done_n  = 1'b0;
        adv           = 1'b0;

        unique case (state)
            S_INIT: begin
                if (!oled_en) begin
                    oled_en_n   = 1'b1;
                    cmd_n       = CMD_INIT;
                    char_addr_n = '0;
                    x_n         = '0;
                    y_n         = '0;
                end else if (oled_done) begin
                    oled_en_n = 1'b0;
                    state_n   = S_CLS;
                end
            end
            S_CLS: begin
                if (!oled_en) begin
                    oled_en_n   = 1'b1;
                    cmd_n       = CMD_CLS;
                    char_addr_n = '0;
                    x_n         = '0;
                    y_n         = '0;
                end else if (oled_done) begin
                    oled_en_n = 1'b0;
                    sh_v_n    = '0;
                    idx_n     = '0;
                    state_n   = (TITLE_LEN == 0) ? S_SNAP : S_TITLE;
                end
            end
            S_TITLE: begin
                if (!oled_en) begin
                    oled_en_n   = 1'b1;
                    cmd_n       = CMD_WR;
                    char_addr_n = GLYPH_W'(TITLE_BASE) + GLYPH_W'(idx);
                    x_n         = 8'(TITLE_X0) + 8'({idx, 4'b0000});
                    y_n         = 3'(TITLE_ROW);
                end else if (oled_done) begin
                    oled_en_n = 1'b0;
                    if (idx == 3'(TITLE_LEN - 1))
                        state_n = S_SNAP;
                    else
                        idx_n = idx + 3'd1;
                end
            end
            S_SNAP: begin
                g_n          = g_calc;
                full_n       = force_pend | force_full;
                force_pend_n = 1'b0;
                idx_n        = 3'(NUM_DIGITS - 1);
                state_n      = S_DIGIT;
            end
            S_DIGIT: begin
                if (!oled_en) begin
                    if (wr) begin
                        oled_en_n   = 1'b1;
                        cmd_n       = CMD_WR;
                        char_addr_n = g[idx];
                        x_n = 8'(DIGIT_X0)
                            + 8'({3'(NUM_DIGITS - 1) - idx, 4'b0000});
                        y_n = 3'(DIGIT_ROW);
                    end else begin
                        adv = 1'b1;
                    end
                end else if (oled_done) begin
                    oled_en_n   = 1'b0;
                    sh_n[idx]   = g[idx];
                    sh_v_n[idx] = 1'b1;
                    adv         = 1'b1;
                end
            end
            S_IDLE: begin
                if (en)
                    state_n = S_SNAP;
            end
            default: state_n = S_INIT;
        endcase

        if (adv) begin
            if (idx == 3'd0) begin
                frame_done_n = 1'b1;
                state_n      = S_IDLE;
            end else begin
                idx_n = idx - 3'd1;
            end
        end

        // Restart only between commands, never while oled_en is held
        if (reinit_pend_n && (!oled_en || oled_done)) begin
            state_n       = S_INIT;
            oled_en_n     = 1'b0;
            frame_done_n  = 1'b0;
            force_pend_n  = 1'b0;
            reinit_pend_n = 1'b0;
        end

        busy_n = (state_n != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_INIT;
            idx         <= '0;
            full        <= 1'b0;
            force_pend  <= 1'b0;
            reinit_pend <= 1'b0;
            sh_v        <= '0;
            for (int k = 0; k < NUM_DIGITS; k++) begin
                g[k]  <= '0;
                sh[k] <= '0;
            end
            oled_en     <= 1'b0;
            cmd         <= '0;
            char_addr   <= '0;
            x           <= '0;
            y           <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            state       <= state_n;
            idx         <= idx_n;
            full        <= full_n;
            force_pend  <= force_pend_n;
            reinit_pend <= reinit_pend_n;
            sh_v        <= sh_v_n;
            g           <= g_n;
            sh          <= sh_n;
            oled_en     <= oled_en_n;
            cmd         <= cmd_n;
            char_addr   <= char_addr_n;
            x           <= x_n;
            y           <= y_n;
            busy        <= busy_n;
            frame_done  <= frame_done_n;
        end
    end

endmodule

// File: tb/tb_zoled_digit_refresher.sv
// Directed bench for zoled_digit_refresher with an auto-completing OLED model.
// Commands are logged as {cmd, char_addr, x, y} when they complete.
module tb_zoled_digit_refresher;

    logic        clk = 1'b0;
    logic        rst, en, force_full, reinit, oled_done;
    logic [31:0] digits;
    logic        oled_en, busy, frame_done;
    logic [3:0]  cmd;
    logic [4:0]  char_addr;
    logic [7:0]  x;
    logic [2:0]  y;

    int          checks = 0;
    int          errors = 0;
    int          frames = 0;
    int          unstable = 0;
    int          drops = 0;
    bit          stall = 1'b0;
    logic [19:0] q[$];

    always #5 clk = ~clk;

    zoled_digit_refresher dut (
        .clk(clk), .rst(rst), .en(en), .digits(digits),
        .force_full(force_full), .reinit(reinit),
        .oled_en(oled_en), .cmd(cmd), .char_addr(char_addr),
        .x(x), .y(y), .oled_done(oled_done),
        .busy(busy), .frame_done(frame_done)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] pk(input logic [3:0] c,
                                       input logic [4:0] a,
                                       input logic [7:0] xx,
                                       input logic [2:0] yy);
        return {c, a, xx, yy};
    endfunction

    // OLED model: completes each command 3 cycles after oled_en rises
    initial begin
        int          cnt;
        bit          active;
        logic [19:0] held;
        cnt = 0;
        active = 1'b0;
        held = '0;
        oled_done = 1'b0;
        forever begin
            @(negedge clk);
            if (frame_done) frames++;
            if (oled_done) begin
                oled_done = 1'b0;
                cnt = 0;
            end else if (oled_en) begin
                if (!active) begin
                    active = 1'b1;
                    held = {cmd, char_addr, x, y};
                end else if ({cmd, char_addr, x, y} != held) begin
                    unstable++;
                end
                if (!stall) begin
                    cnt++;
                    if (cnt >= 3) begin
                        oled_done = 1'b1;
                        q.push_back(held);
                        active = 1'b0;
                    end
                end
            end else if (active) begin
                drops++;
                active = 1'b0;
                cnt = 0;
            end
        end
    end

    task automatic wait_frame(input int f0, input string tag);
        int n;
        n = 0;
        while (frames == f0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_frame_seen"}, 32'(frames != f0), 32'd1);
    endtask

    task automatic run_pass(input string tag);
        int f0;
        q.delete();
        f0 = frames;
        @(negedge clk) en = 1'b1;
        @(negedge clk) en = 1'b0;
        wait_frame(f0, tag);
        repeat (3) @(negedge clk);
        check({tag, "_frames"}, 32'(frames), 32'(f0 + 1));
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int          f0;
        logic [4:0]  ca457 [8];
        logic [4:0]  ca458 [8];
        ca457 = '{5'd16, 5'd16, 5'd16, 5'd16, 5'd16, 5'd10, 5'd11, 5'd13};
        ca458 = '{5'd16, 5'd16, 5'd16, 5'd16, 5'd16, 5'd10, 5'd11, 5'd14};

        rst = 1'b1;
        en = 1'b0;
        force_full = 1'b0;
        reinit = 1'b0;
        digits = 32'h0000_0457;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {oled_en, cmd, char_addr, x, y, busy, frame_done},
              32'd0);

        // Power-up sequence plus first digit pass
        rst = 1'b0;
        wait_frame(0, "boot");
        repeat (3) @(negedge clk);
        check("boot_frames", 32'(frames), 32'd1);
        check("boot_count", 32'(q.size()), 32'd16);
        if (q.size() >= 16) begin
            check("boot_init", 32'(q[0]), 32'(pk(4'd0, 5'd0, 8'd0, 3'd0)));
            check("boot_cls_cmd", 32'(q[1][19:16]), 32'd1);
            for (int i = 0; i < 6; i++)
                check($sformatf("title%0d", i), 32'(q[2+i]),
                      32'(pk(4'd2, 5'(i), 8'(16 + 16*i), 3'd0)));
            for (int j = 0; j < 8; j++)
                check($sformatf("d457_%0d", j), 32'(q[8+j]),
                      32'(pk(4'd2, ca457[j], 8'(16*j), 3'd2)));
        end

        run_pass("same");
        check("same_count", 32'(q.size()), 32'd0);

        digits = 32'h0000_0458;
        run_pass("one_change");
        check("one_count", 32'(q.size()), 32'd1);
        if (q.size() >= 1)
            check("one_wr", 32'(q[0]),
                  32'(pk(4'd2, 5'd14, 8'd112, 3'd2)));

        // force_full raised mid-pass applies to the following pass
        q.delete();
        f0 = frames;
        @(negedge clk) en = 1'b1;
        @(negedge clk) en = 1'b0;
        @(negedge clk);
        @(negedge clk) force_full = 1'b1;
        @(negedge clk) force_full = 1'b0;
        wait_frame(f0, "force_arm");
        check("force_arm_count", 32'(q.size()), 32'd0);
        run_pass("force");
        check("force_count", 32'(q.size()), 32'd8);
        if (q.size() >= 8)
            for (int j = 0; j < 8; j++)
                check($sformatf("force_%0d", j), 32'(q[j]),
                      32'(pk(4'd2, ca458[j], 8'(16*j), 3'd2)));

        digits = 32'h0000_000A;
        run_pass("invalid");
        check("invalid_count", 32'(q.size()), 32'd3);
        if (q.size() >= 3)
            check("invalid_lsd", 32'(q[2]),
                  32'(pk(4'd2, 5'd16, 8'd112, 3'd2)));

        // Stall the first WR, request reinit while it is held
        digits = 32'h1234_5678;
        stall = 1'b1;
        q.delete();
        f0 = frames;
        @(negedge clk) en = 1'b1;
        @(negedge clk) en = 1'b0;
        for (int n = 0; n < 50 && !oled_en; n++) @(negedge clk);
        repeat (50) @(negedge clk);
        check("stall_held_en", 32'(oled_en), 32'd1);
        check("stall_nodone", 32'(q.size()), 32'd0);
        @(negedge clk) reinit = 1'b1;
        @(negedge clk) reinit = 1'b0;
        repeat (5) @(negedge clk);
        stall = 1'b0;
        wait_frame(f0, "reinit");
        repeat (3) @(negedge clk);
        check("stable", 32'(unstable), 32'd0);
        check("no_drop", 32'(drops), 32'd0);
        check("reinit_frames", 32'(frames), 32'(f0 + 1));
        check("reinit_count", 32'(q.size()), 32'd17);
        if (q.size() >= 17) begin
            check("reinit_first_wr", 32'(q[0]),
                  32'(pk(4'd2, 5'd7, 8'd0, 3'd2)));
            check("reinit_init", 32'(q[1]),
                  32'(pk(4'd0, 5'd0, 8'd0, 3'd0)));
            check("reinit_cls_cmd", 32'(q[2][19:16]), 32'd1);
            check("reinit_msd", 32'(q[9]),
                  32'(pk(4'd2, 5'd7, 8'd0, 3'd2)));
            check("reinit_lsd", 32'(q[16]),
                  32'(pk(4'd2, 5'd14, 8'd112, 3'd2)));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
